regfile_port_ctrl: RTL and testbench
====================================

REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 Parameter DW, 16, data width of one register and of the write/bypass data paths.
REQ-002 Parameter NREG, 16, register count; register ids are log2(NREG)=4 bits.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_req_a  in  1  requester A (ALU writeback) write request; held until acked.
REQ-006 wr_reg_a  in  4  requester A destination register id.
REQ-007 wr_data_a  in  DW  requester A write data.
REQ-008 wr_ack_a  out  1  requester A granted this cycle.
REQ-009 wr_req_b / wr_reg_b / wr_data_b / wr_ack_b: same as REQ-005..008 for requester B (memory writeback).
REQ-010 rd_en  in  1  read ports active this cycle.
REQ-011 rd_reg1, rd_reg2  in  4 each  read port 1/2 register ids.
REQ-012 WriteEnable  out  NREG  one-hot bitcell-row write enable.
REQ-013 wr_data  out  DW  data driven to all bitcell D inputs.
REQ-014 ReadEnable1, ReadEnable2  out  NREG each  one-hot row enables for Bitline1/Bitline2.
REQ-015 bypass1, bypass2  out  1 each  read port 1/2 must take bypass_data instead of bitline.
REQ-016 bypass_data  out  DW  data currently in the write stage.
REQ-017 wr_count  out  8  count of committed register writes, wraps.

Function
REQ-018 Arbitration combinational in cycle N; wr_ack_x high in cycle N for the winner only; at most one ack per cycle.
REQ-019 Single requester: granted immediately.
REQ-020 Both requesting: round-robin; winner is the requester not granted last; last_grant flop updates only on a grant.
REQ-021 Winner's reg id and data captured at posedge ending cycle N into the write stage (ws_valid, ws_reg, ws_data).
REQ-022 During cycle N+1: WriteEnable = onehot(ws_reg) when ws_valid, else all zero; wr_data = ws_data; bitcell writes at posedge ending N+1. Grant-to-write latency = 1 cycle.
REQ-023 Write stage accepts a new grant every cycle (no backpressure beyond arbitration loss).
REQ-024 Writes to register 0: acked normally, ws_valid stays 0, no WriteEnable, wr_count not incremented.
REQ-025 ReadEnable1/2 = onehot(rd_reg1/2) when rd_en, else all zero; purely combinational, same cycle.
REQ-026 bypass1 = rd_en & ws_valid & (rd_reg1 == ws_reg); bypass2 likewise; bypass_data = ws_data always.
REQ-027 Read of register 0 never bypasses (ws_valid never set for reg 0).
REQ-028 wr_count increments by 1 on each cycle with ws_valid=1; 8'hFF wraps to 8'h00.
REQ-029 Both requesters targeting the same register: loser written in a later cycle, so the loser's data is the final value.
REQ-030 A deasserting request before ack: no write, no state change.

Reset
REQ-031 rst asserted: ws_valid=0, ws_reg=0, ws_data=0, last_grant=B, wr_count=0, immediately (asynchronous).
REQ-032 During rst: wr_ack_a=wr_ack_b=0, WriteEnable=0, ReadEnable1/2=0, bypass1/2=0, wr_data=0, bypass_data=0.
REQ-033 A grant in flight when rst asserts is discarded; no WriteEnable after rst deasserts until a new grant.
REQ-034 First grant after reset with both requesting goes to A.

Verification
REQ-035 Reset, then A req reg 3 data 16'hBEEF -> wr_ack_a same cycle; next cycle WriteEnable=16'h0008, wr_data=16'hBEEF; wr_count=1.
REQ-036 A and B request for 4 cycles (A reg 1, B reg 2) -> acks A,B,A,B; WriteEnable 16'h0002,16'h0004,16'h0002,16'h0004 one cycle later.
REQ-037 Write reg 5 data 16'h1234 with rd_en=1, rd_reg1=5, rd_reg2=6 in the write cycle -> bypass1=1, bypass2=0, bypass_data=16'h1234, ReadEnable1=16'h0020, ReadEnable2=16'h0040.
REQ-038 B writes reg 0 -> wr_ack_b=1, WriteEnable stays 0, wr_count unchanged, rd_reg1=0 gives bypass1=0.
REQ-039 Assert rst the cycle after a grant -> WriteEnable=0 and wr_count=0 immediately; after release no write occurs without a new request.
REQ-040 Perform 256 committed writes -> wr_count returns to 8'h00.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: round-robin arbitration of two writeback
// requesters into a one-cycle write stage, one-hot row decode and read bypass.
module regfile_port_ctrl #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            wr_req_a,
    input  logic [RW-1:0]   wr_reg_a,
    input  logic [DW-1:0]   wr_data_a,
    output logic            wr_ack_a,

    input  logic            wr_req_b,
    input  logic [RW-1:0]   wr_reg_b,
    input  logic [DW-1:0]   wr_data_b,
    output logic            wr_ack_b,

    input  logic            rd_en,
    input  logic [RW-1:0]   rd_reg1,
    input  logic [RW-1:0]   rd_reg2,

    output logic [NREG-1:0] WriteEnable,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] ReadEnable1,
    output logic [NREG-1:0] ReadEnable2,
    output logic            bypass1,
    output logic            bypass2,
    output logic [DW-1:0]   bypass_data,
    output logic [7:0]      wr_count
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t          last_grant;
    grant_t          last_grant_next;
    logic            grant_a;
    logic            grant_b;
    logic            grant_any;
    logic [RW-1:0]   grant_reg;
    logic [DW-1:0]   grant_data;

    logic            ws_valid;
    logic [RW-1:0]   ws_reg;
    logic [DW-1:0]   ws_data;
    logic [7:0]      count;

    function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
        logic [NREG-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Arbiter state: remembers who won the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        grant_a         = 1'b0;
        grant_b         = 1'b0;
        last_grant_next = last_grant;
        if (!rst) begin
            if (wr_req_a && wr_req_b) begin
                // On a tie the requester that did not win last time goes first.
                grant_a = (last_grant == GRANT_B);
                grant_b = (last_grant == GRANT_A);
            end else begin
                grant_a = wr_req_a;
                grant_b = wr_req_b;
            end
            if (grant_a) begin
                last_grant_next = GRANT_A;
            end else if (grant_b) begin
                last_grant_next = GRANT_B;
            end
        end
    end

    assign grant_any  = grant_a | grant_b;
    assign grant_reg  = grant_b ? wr_reg_b  : wr_reg_a;
    assign grant_data = grant_b ? wr_data_b : wr_data_a;
    assign wr_ack_a   = grant_a;
    assign wr_ack_b   = grant_b;

    // Write stage: winner captured here, drives the bitcells during the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_valid <= 1'b0;
            ws_reg   <= '0;
            ws_data  <= '0;
        end else begin
            // Register 0 is hardwired: the grant is consumed but nothing is written.
            ws_valid <= grant_any && (grant_reg != '0);
            if (grant_any) begin
                ws_reg  <= grant_reg;
                ws_data <= grant_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'h00;
        end else if (ws_valid) begin
            count <= count + 8'd1;
        end
    end

    assign WriteEnable = ws_valid ? onehot(ws_reg) : '0;
    assign wr_data     = ws_data;
    assign bypass_data = ws_data;
    assign wr_count    = count;

    // Read decode is combinational and forced quiet while reset is held.
    assign ReadEnable1 = (rd_en && !rst) ? onehot(rd_reg1) : '0;
    assign ReadEnable2 = (rd_en && !rst) ? onehot(rd_reg2) : '0;
    assign bypass1     = rd_en && !rst && ws_valid && (rd_reg1 == ws_reg);
    assign bypass2     = rd_en && !rst && ws_valid && (rd_reg2 == ws_reg);

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Randomized scoreboard bench for regfile_port_ctrl: a behavioural model
// predicts every cycle's outputs, a monitor pops and compares them.
module tb_regfile_port_ctrl;
    localparam int DW   = 16;
    localparam int NREG = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_req_a = 1'b0, wr_req_b = 1'b0;
    logic [3:0]      wr_reg_a = '0, wr_reg_b = '0;
    logic [DW-1:0]   wr_data_a = '0, wr_data_b = '0;
    logic            wr_ack_a, wr_ack_b;
    logic            rd_en = 1'b0;
    logic [3:0]      rd_reg1 = '0, rd_reg2 = '0;
    logic [NREG-1:0] WriteEnable, ReadEnable1, ReadEnable2;
    logic [DW-1:0]   wr_data, bypass_data;
    logic            bypass1, bypass2;
    logic [7:0]      wr_count;

    regfile_port_ctrl #(.DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .wr_req_a(wr_req_a), .wr_reg_a(wr_reg_a), .wr_data_a(wr_data_a), .wr_ack_a(wr_ack_a),
        .wr_req_b(wr_req_b), .wr_reg_b(wr_reg_b), .wr_data_b(wr_data_b), .wr_ack_b(wr_ack_b),
        .rd_en(rd_en), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .WriteEnable(WriteEnable), .wr_data(wr_data),
        .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
        .bypass1(bypass1), .bypass2(bypass2), .bypass_data(bypass_data),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            ack_a;
        logic            ack_b;
        logic [NREG-1:0] we;
        logic [DW-1:0]   wd;
        logic [NREG-1:0] re1;
        logic [NREG-1:0] re2;
        logic            byp1;
        logic            byp2;
        logic [DW-1:0]   bd;
        logic [7:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    bit   done = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: "whose turn on a tie", the write waiting to land, the tally.
    bit          m_turn_a = 1'b1;
    bit          m_pend   = 1'b0;
    int          m_preg   = 0;
    logic [15:0] m_pdata  = '0;
    int          m_writes = 0;
    bit          m_ga = 1'b0, m_gb = 1'b0;

    task automatic step(input bit r,
                        input bit a, input int ar, input logic [15:0] ad,
                        input bit b, input int br, input logic [15:0] bd,
                        input bit re, input int r1, input int r2);
        exp_t e;
        rst = r;
        wr_req_a = a; wr_reg_a = 4'(ar); wr_data_a = ad;
        wr_req_b = b; wr_reg_b = 4'(br); wr_data_b = bd;
        rd_en = re; rd_reg1 = 4'(r1); rd_reg2 = 4'(r2);

        m_ga = 1'b0; m_gb = 1'b0;
        if (!r) begin
            if (a && b) begin
                m_ga = m_turn_a;
                m_gb = !m_turn_a;
            end else begin
                m_ga = a;
                m_gb = b;
            end
        end
        e.ack_a = m_ga;
        e.ack_b = m_gb;
        if (r) begin
            e.we = '0; e.wd = '0; e.re1 = '0; e.re2 = '0;
            e.byp1 = 1'b0; e.byp2 = 1'b0; e.bd = '0; e.cnt = '0;
        end else begin
            e.we   = m_pend ? (NREG'(1) << m_preg) : '0;
            e.wd   = m_pdata;
            e.bd   = m_pdata;
            e.re1  = re ? (NREG'(1) << r1) : '0;
            e.re2  = re ? (NREG'(1) << r2) : '0;
            e.byp1 = re && m_pend && (r1 == m_preg);
            e.byp2 = re && m_pend && (r2 == m_preg);
            e.cnt  = 8'(m_writes % 256);
        end
        exp_q.push_back(e);

        @(posedge clk);
        if (r) begin
            m_turn_a = 1'b1; m_pend = 1'b0; m_preg = 0; m_pdata = '0; m_writes = 0;
        end else begin
            if (m_pend) m_writes++;
            m_pend = 1'b0;
            if (m_ga || m_gb) begin
                m_preg   = m_ga ? ar : br;
                m_pdata  = m_ga ? ad : bd;
                m_pend   = (m_preg != 0);
                m_turn_a = m_gb;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs.
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (done) break;
                continue;
            end
            e = exp_q.pop_front();
            chk("wr_ack_a",    32'(wr_ack_a),    32'(e.ack_a));
            chk("wr_ack_b",    32'(wr_ack_b),    32'(e.ack_b));
            chk("WriteEnable", 32'(WriteEnable), 32'(e.we));
            chk("wr_data",     32'(wr_data),     32'(e.wd));
            chk("ReadEnable1", 32'(ReadEnable1), 32'(e.re1));
            chk("ReadEnable2", 32'(ReadEnable2), 32'(e.re2));
            chk("bypass1",     32'(bypass1),     32'(e.byp1));
            chk("bypass2",     32'(bypass2),     32'(e.byp2));
            chk("bypass_data", 32'(bypass_data), 32'(e.bd));
            chk("wr_count",    32'(wr_count),    32'(e.cnt));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bit          a_act = 0, b_act = 0, r;
        int          a_reg = 0, b_reg = 0, r1, r2;
        logic [15:0] a_dat = '0, b_dat = '0;

        @(posedge clk);
        #1;
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 3, 4);
        step(1, 1, 3, 16'h1111, 1, 4, 16'h2222, 0, 0, 0);

        step(0, 1, 3, 16'hBEEF, 0, 0, 16'h0, 0, 0, 0);
        idle(2);

        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'hA001, 1, 2, 16'hB002, 0, 0, 0);
        idle(2);

        step(0, 1, 5, 16'h1234, 0, 0, 16'h0, 0, 0, 0);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 5, 6);
        idle(1);

        step(0, 0, 0, 16'h0, 1, 0, 16'hDEAD, 0, 0, 0);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0);
        idle(1);

        step(0, 1, 7, 16'h7777, 0, 0, 16'h0, 0, 0, 0);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 7, 7);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
        idle(2);

        step(0, 1, 9, 16'h0009, 1, 9, 16'h0090, 0, 0, 0);
        step(0, 0, 0, 16'h0, 1, 9, 16'h0090, 1, 9, 0);
        idle(2);

        for (int i = 0; i < 258; i++)
            step(0, 1, (i % 15) + 1, 16'(i * 3 + 1), 0, 0, 16'h0, 1, i % 16, (i + 1) % 16);
        idle(2);

        for (int c = 0; c < 2000; c++) begin
            if (a_act && m_ga) a_act = 0;
            if (b_act && m_gb) b_act = 0;
            if (!a_act && $urandom_range(0, 1) == 1) begin
                a_act = 1; a_reg = $urandom_range(0, 15); a_dat = 16'($urandom);
            end else if (a_act && $urandom_range(0, 15) == 0) begin
                a_act = 0;
            end
            if (!b_act && $urandom_range(0, 1) == 1) begin
                b_act = 1; b_reg = $urandom_range(0, 15); b_dat = 16'($urandom);
            end else if (b_act && $urandom_range(0, 15) == 0) begin
                b_act = 0;
            end
            r  = ($urandom_range(0, 99) == 0);
            r1 = ($urandom_range(0, 1) == 1) ? m_preg : int'($urandom_range(0, 15));
            r2 = ($urandom_range(0, 2) == 0) ? m_preg : int'($urandom_range(0, 15));
            step(r, a_act, a_reg, a_dat, b_act, b_reg, b_dat,
                 $urandom_range(0, 3) != 0, r1, r2);
        end
        idle(3);
        done = 1'b1;
    end

endmodule
